serial_magnitude_comparator: RTL and testbench

Bit-serial magnitude comparator. It compares two WIDTH-bit unsigned operands, one bit per clock, MSB first, instead of using a spatial cascade of bit stages. It accepts an operand pair with a start/busy/done handshake and returns registered greater/equal/less flags. It is the time-multiplexed counterpart of the team's cascaded comparators and is used where area matters more than latency.

---
 rtl/serial_magnitude_comparator_pkg.sv | 15 +
 rtl/serial_magnitude_comparator_step.sv | 18 +
 rtl/serial_magnitude_comparator.sv | 128 ++++++++++++
 tb/tb_serial_magnitude_comparator.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_magnitude_comparator_pkg.sv
// Shared types for the bit-serial magnitude comparator: FSM encoding and
// the power-up value of the visible result flags.
package serial_magnitude_comparator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic G_RST = 1'b0;
    localparam logic E_RST = 1'b0;
    localparam logic L_RST = 1'b0;

endpackage

// File: rtl/serial_magnitude_comparator_step.sv
// One MSB-first compare step: the first differing bit decides the result,
// after which the flags freeze (ei low blocks any further update).
module serial_cmp_step (
    input  logic gi,
    input  logic ei,
    input  logic li,
    input  logic x,
    input  logic y,
    output logic gi_next,
    output logic ei_next,
    output logic li_next
);

    assign gi_next = gi | (ei & x & ~y);
    assign li_next = li | (ei & ~x & y);
    assign ei_next = ei & ~(x ^ y);

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Bit-serial unsigned comparator: one operand bit per clock, MSB first,
// with start/busy/done handshake and registered g/e/l result flags.
module serial_magnitude_comparator
    import serial_magnitude_comparator_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             g,
    output logic             e,
    output logic             l
);

    localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] sa_reg, sb_reg;
    logic [CW-1:0]    cnt_reg;
    logic             gi_reg, ei_reg, li_reg;
    logic             gi_next, ei_next, li_next;
    logic             g_reg, e_reg, l_reg;
    logic             accept;
    logic             last_step;

    serial_cmp_step u_step (
        .gi      (gi_reg),
        .ei      (ei_reg),
        .li      (li_reg),
        .x       (sa_reg[WIDTH-1]),
        .y       (sb_reg[WIDTH-1]),
        .gi_next (gi_next),
        .ei_next (ei_next),
        .li_next (li_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // DONE accepts a new start so back-to-back pairs skip the IDLE cycle.
    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        last_step  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                last_step = (cnt_reg == '0) || (EARLY_EXIT && !ei_next);
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa_reg  <= '0;
            sb_reg  <= '0;
            cnt_reg <= '0;
            gi_reg  <= 1'b0;
            ei_reg  <= 1'b1;
            li_reg  <= 1'b0;
        end else if (accept) begin
            sa_reg  <= a;
            sb_reg  <= b;
            cnt_reg <= CNT_LOAD;
            gi_reg  <= 1'b0;
            ei_reg  <= 1'b1;
            li_reg  <= 1'b0;
        end else if (state_reg == RUN) begin
            sa_reg <= sa_reg << 1;
            sb_reg <= sb_reg << 1;
            gi_reg <= gi_next;
            ei_reg <= ei_next;
            li_reg <= li_next;
            // Hold at zero rather than wrapping on the exit edge.
            if (cnt_reg != '0) begin
                cnt_reg <= cnt_reg - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g_reg <= G_RST;
            e_reg <= E_RST;
            l_reg <= L_RST;
        end else if (last_step) begin
            g_reg <= gi_next;
            e_reg <= ei_next;
            l_reg <= li_next;
        end
    end

    assign busy = (state_reg == RUN);
    assign done = (state_reg == DONE);
    assign g    = g_reg;
    assign e    = e_reg;
    assign l    = l_reg;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Directed bench for the bit-serial comparator: one instance per EARLY_EXIT
// setting, inputs driven and outputs sampled on the falling clock edge.
module tb_serial_magnitude_comparator;

    logic       clk;
    logic       rst_n;
    logic       start0, start1;
    logic [3:0] a0, b0, a1, b1;
    logic       busy0, done0, g0, e0, l0;
    logic       busy1, done1, g1, e1, l1;

    logic       sel;
    logic       busy_s, done_s;
    logic [2:0] gel_s;

    int checks;
    int errors;

    serial_magnitude_comparator #(.WIDTH(4), .EARLY_EXIT(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .a(a0), .b(b0),
        .busy(busy0), .done(done0), .g(g0), .e(e0), .l(l0)
    );

    serial_magnitude_comparator #(.WIDTH(4), .EARLY_EXIT(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .g(g1), .e(e1), .l(l1)
    );

    assign busy_s = sel ? busy1 : busy0;
    assign done_s = sel ? done1 : done0;
    assign gel_s  = sel ? {g1, e1, l1} : {g0, e0, l0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end else begin
            $display("ok   %s: %0h", tag, act);
        end
    endtask

    // Starts one comparison and waits (bounded) for done; returns at the
    // falling edge of the DONE cycle with latency counted in clocks.
    task automatic run_cmp(input logic ee, input logic [3:0] av, input logic [3:0] bv,
                           output int lat, output logic [2:0] gel);
        @(negedge clk);
        sel = ee;
        if (ee) begin
            start1 = 1'b1; a1 = av; b1 = bv;
        end else begin
            start0 = 1'b1; a0 = av; b0 = bv;
        end
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        check("busy_after_start", 32'(busy_s), 32'(1'b1));
        lat = 0;
        while (done_s !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("busy_low_in_done", 32'(busy_s), 32'(1'b0));
        gel = gel_s;
    endtask

    function automatic logic [2:0] ref_gel(input logic [3:0] av, input logic [3:0] bv);
        if (av > bv) return 3'b100;
        if (av == bv) return 3'b010;
        return 3'b001;
    endfunction

    int         lat;
    int         exp_lat;
    logic [2:0] gel;
    logic [3:0] diff;
    logic [3:0] sa, sb;
    logic       found;
    logic       seen;

    initial begin
        checks = 0;
        errors = 0;
        sel    = 1'b0;
        rst_n  = 1'b0;
        start0 = 1'b0; a0 = '0; b0 = '0;
        start1 = 1'b0; a1 = '0; b1 = '0;

        #1;
        check("reset_busy0", 32'(busy0), 32'(1'b0));
        check("reset_done0", 32'(done0), 32'(1'b0));
        check("reset_gel0", 32'({g0, e0, l0}), 32'(3'b000));
        check("reset_gel1", 32'({g1, e1, l1}), 32'(3'b000));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Directed, EARLY_EXIT=0: always WIDTH cycles.
        run_cmp(1'b0, 4'd9, 4'd6, lat, gel);
        check("ee0_9_6_lat", 32'(lat), 32'(4));
        check("ee0_9_6_gel", 32'(gel), 32'(3'b100));
        run_cmp(1'b0, 4'd5, 4'd5, lat, gel);
        check("ee0_5_5_lat", 32'(lat), 32'(4));
        check("ee0_5_5_gel", 32'(gel), 32'(3'b010));
        run_cmp(1'b0, 4'd3, 4'd12, lat, gel);
        check("ee0_3_12_gel", 32'(gel), 32'(3'b001));

        // Directed, EARLY_EXIT=1.
        run_cmp(1'b1, 4'd8, 4'd7, lat, gel);
        check("ee1_8_7_lat", 32'(lat), 32'(1));
        check("ee1_8_7_gel", 32'(gel), 32'(3'b100));
        run_cmp(1'b1, 4'd4, 4'd5, lat, gel);
        check("ee1_4_5_lat", 32'(lat), 32'(4));
        check("ee1_4_5_gel", 32'(gel), 32'(3'b001));

        // Start pulsed during RUN with other operands must be ignored.
        @(negedge clk);
        sel = 1'b0;
        start0 = 1'b1; a0 = 4'd9; b0 = 4'd6;
        @(negedge clk);
        a0 = 4'd2; b0 = 4'd14;
        @(negedge clk);
        start0 = 1'b0;
        lat = 1;
        while (done0 !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("ignore_start_lat", 32'(lat), 32'(4));
        check("ignore_start_gel", 32'({g0, e0, l0}), 32'(3'b100));

        // Start held through DONE: next RUN follows with no IDLE cycle.
        @(negedge clk);
        start0 = 1'b1; a0 = 4'd3; b0 = 4'd12;
        @(negedge clk);
        lat = 0;
        while (done0 !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("b2b_first_lat", 32'(lat), 32'(4));
        check("b2b_first_gel", 32'({g0, e0, l0}), 32'(3'b001));
        a0 = 4'd12; b0 = 4'd3;
        @(negedge clk);
        start0 = 1'b0;
        check("b2b_busy_no_idle", 32'(busy0), 32'(1'b1));
        check("b2b_hold_gel", 32'({g0, e0, l0}), 32'(3'b001));
        lat = 0;
        while (done0 !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("b2b_second_lat", 32'(lat), 32'(4));
        check("b2b_second_gel", 32'({g0, e0, l0}), 32'(3'b100));

        // Asynchronous reset in the middle of RUN.
        @(negedge clk);
        start0 = 1'b1; a0 = 4'd1; b0 = 4'd2;
        @(negedge clk);
        start0 = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("midrun_rst_busy", 32'(busy0), 32'(1'b0));
        check("midrun_rst_done", 32'(done0), 32'(1'b0));
        check("midrun_rst_gel", 32'({g0, e0, l0}), 32'(3'b000));
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done0 === 1'b1) seen = 1'b1;
        end
        check("midrun_rst_no_done", 32'(seen), 32'(1'b0));

        // Exhaustive sweep, both variants.
        for (int ee = 0; ee < 2; ee++) begin
            for (int i = 0; i < 256; i++) begin
                sa = 4'(i >> 4);
                sb = 4'(i);
                run_cmp(ee[0], sa, sb, lat, gel);
                diff    = sa ^ sb;
                exp_lat = 4;
                found   = 1'b0;
                if (ee == 1) begin
                    for (int p = 3; p >= 0; p--) begin
                        if (!found && diff[p]) begin
                            exp_lat = 4 - p;
                            found   = 1'b1;
                        end
                    end
                end
                check($sformatf("sweep_ee%0d_%0d_%0d_gel", ee, sa, sb), 32'(gel), 32'(ref_gel(sa, sb)));
                check($sformatf("sweep_ee%0d_%0d_%0d_lat", ee, sa, sb), 32'(lat), 32'(exp_lat));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
